// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, majority-sample ticks, divisor.
// State PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Each bit is decided by a 2-of-3 vote over these oversample ticks.
    localparam int unsigned SAMPLE_T0 = 7;
    localparam int unsigned SAMPLE_T1 = 8;
    localparam int unsigned SAMPLE_T2 = 9;

    function automatic int unsigned calc_divisor(input int unsigned sys_clk,
                                                 input int unsigned baud,
                                                 input int unsigned os);
        return sys_clk / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIVISOR clocks, restartable via clear.
module uart_baud_tick #(
    parameter int unsigned DIVISOR = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (cnt == CW'(DIVISOR - 1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == CW'(DIVISOR - 1));

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 2-of-3 majority voting and valid/ready output.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SYSTEM_CLK = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_pin,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam int unsigned DIVISOR  = calc_divisor(SYSTEM_CLK, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned BIT_CLKS = DIVISOR * OVERSAMPLE;
    localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned IW = $clog2(BIT_CLKS + 1);

    rx_state_t state, state_next;

    logic                  sync1, sync2, sync_d;
    logic                  fell;
    logic                  tick;
    logic [TW-1:0]         tick_cnt;
    logic                  s7, s8;
    logic                  vote, vote_tick;
    logic [BW-1:0]         bit_cnt;
    logic [IW-1:0]         idle_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  deliver;
    logic                  restart, shift_en, stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                  par_cap, par_bit, parity_err_q;
`endif

    uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (restart),
        .tick  (tick)
    );

    assign fell      = sync_d & ~sync2;
    assign vote_tick = tick && (tick_cnt == TW'(SAMPLE_T2));
    assign vote      = (s7 & s8) | (s7 & sync2) | (s8 & sync2);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Transitions happen at the vote tick; the tick counter keeps running so the
    // next bit's vote lands exactly one bit time later.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        shift_en   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fell) begin
                    restart    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (vote_tick)
                    state_next = vote ? IDLE : DATA;
            end
            DATA: begin
                if (vote_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (vote_tick) begin
                    par_cap    = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (vote_tick) begin
                    if (vote) begin
                        stop_ok    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (sync2 && idle_cnt == IW'(BIT_CLKS - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_d    <= 1'b1;
            tick_cnt  <= '0;
            s7        <= 1'b0;
            s8        <= 1'b0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            shift_reg <= '0;
            deliver   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1  <= rx_pin;
            sync2  <= sync1;
            sync_d <= sync2;

            if (restart)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= (tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TW'(1);

            if (tick && tick_cnt == TW'(SAMPLE_T0)) s7 <= sync2;
            if (tick && tick_cnt == TW'(SAMPLE_T1)) s8 <= sync2;

            if (restart)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + BW'(1);

            if (shift_en)
                shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};

            // Break handling: the line must stay high for a whole bit time.
            if (state == WAIT_IDLE && sync2)
                idle_cnt <= idle_cnt + IW'(1);
            else
                idle_cnt <= '0;

            deliver   <= stop_ok;
            frame_err <= stop_bad;
            overrun   <= 1'b0;

            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (par_cap)
                par_bit <= vote;
            parity_err_q <= deliver && ((^shift_reg) ^ par_bit);
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed scoreboard bench for uart_rx_os; parity scenarios run when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_pin = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err;

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          ferr_cnt = 0, ovr_cnt = 0, par_cnt = 0;
    int          rise_cyc = 0, stop_start = 0;
    logic        valid_d = 1'b0;
    logic [7:0]  sb_q[$];
`ifdef UART_RX_PARITY_EN
    logic        par_flip = 1'b0;
`endif

    uart_rx_os #(
        .DATA_WIDTH (8),
        .SYSTEM_CLK (50_000_000),
        .BAUD_RATE  (115_200),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_pin     (rx_pin),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every rising rx_valid must match the oldest queued byte.
    always @(negedge clk) begin
        if (frame_err)  ferr_cnt++;
        if (overrun)    ovr_cnt++;
        if (parity_err) par_cnt++;
        if (rx_valid && !valid_d) begin
            rise_cyc = cyc;
            if (sb_q.size() == 0)
                check("spurious_valid", 32'(rx_valid), 32'd0);
            else
                check("sb_rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
        end
        valid_d = rx_valid;
    end

    task automatic drive_bit(input logic v);
        rx_pin = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        stop_start = cyc;
        drive_bit(stop);
        rx_pin = 1'b1;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        reset = 1'b0;
        repeat (50) @(negedge clk);

        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_latency", ((rise_cyc - stop_start) >= 265) && ((rise_cyc - stop_start) <= 285), 1);
        consume();
        check("a5_consumed", rx_valid, 0);

        sb_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("3c_data", rx_data, 8'h3C);
        rx_ready = 1'b1;
        check("3c_hold_before_edge", rx_valid, 1);
        @(negedge clk);
        rx_ready = 1'b0;
        check("3c_cleared", rx_valid, 0);

        rx_pin = 1'b0;
        repeat (100) @(negedge clk);
        rx_pin = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_no_valid", rx_valid, 0);
        check("glitch_no_ferr", ferr_cnt, 0);

        // Bad stop bit; a frame sent before the line has idled a bit time is ignored.
        send_frame(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        send_frame(8'h00, 1'b1);
        repeat (500) @(negedge clk);
        check("ferr_once", ferr_cnt, 1);
        check("ferr_no_valid", rx_valid, 0);
        sb_q.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        check("after_break_data", rx_data, 8'h96);
        check("after_break_valid", rx_valid, 1);
        consume();

        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        check("ovr_once", ovr_cnt, 1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_valid_kept", rx_valid, 1);

        // Reset during bit 4 of 0xFF, with 0x11 still pending.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_pin = 1'b1;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_overrun", overrun, 0);
        reset = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        check("midrst_no_delivery", rx_valid, 0);
        check("midrst_no_ferr", ferr_cnt, 1);
        sb_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("post_rst_data", rx_data, 8'h81);
        check("post_rst_valid", rx_valid, 1);
        consume();

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        sb_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        check("par_bad_err", par_cnt, 1);
        check("par_bad_data", rx_data, 8'h07);
        check("par_bad_valid", rx_valid, 1);
        consume();
        sb_q.push_back(8'h03);
        send_frame(8'h03, 1'b1);
        check("par_good_no_err", par_cnt, 1);
        check("par_good_data", rx_data, 8'h03);
        consume();
`else
        check("no_parity_err", par_cnt, 0);
`endif

        repeat (20) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        check("ovr_total", ovr_cnt, 1);
        check("ferr_total", ferr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
